// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I MEM-stage data memory with byte/half/word access,
// misalignment/illegal-funct3 detection, configurable wait states and a
// post-reset zero-fill sequencer.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        clear_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e            state_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [3:0]        wcnt_q;
  req_t              req_q;
  logic              ready_q, valid_q, err_q, busy_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  req_t              req_in, op;
  logic              accept, enter_resp, st_en;
  logic [IDX_W-1:0]  op_idx;
  logic [31:0]       rd_word, ext, ld_data, wd;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [3:0]        be;
  logic              err_c;
  logic              unused_addr;

  assign req_in     = '{wr: req_write, f3: req_funct3, addr: req_addr, wdata: req_wdata};
  assign accept     = req_valid & ready_q;
  // With no wait states the access happens on the accept edge itself, so it
  // must use the live request; otherwise it uses the latched copy.
  assign enter_resp = (WAIT_STATES == 0) ? accept : (state_q == S_WAIT && wcnt_q == 4'd0);
  assign op         = (WAIT_STATES == 0) ? req_in : req_q;
  assign op_idx     = op.addr[IDX_W+1:2];
  assign rd_word    = mem_q[op_idx];
  assign byte_c     = rd_word[{op.addr[1:0], 3'b000} +: 8];
  assign half_c     = op.addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign unused_addr = ^op.addr[31:IDX_W+2];

  // Decode access: error, byte enables, store lanes and extended load data
  always_comb begin
    err_c = 1'b0;
    be    = 4'b0000;
    wd    = op.wdata;
    ext   = 32'd0;
    if (op.wr) begin
      case (op.f3)
        3'b000: begin
          be = 4'b0001 << op.addr[1:0];
          wd = {4{op.wdata[7:0]}};
        end
        3'b001: begin
          err_c = op.addr[0];
          be    = op.addr[1] ? 4'b1100 : 4'b0011;
          wd    = {2{op.wdata[15:0]}};
        end
        3'b010: begin
          err_c = |op.addr[1:0];
          be    = 4'b1111;
        end
        default: err_c = 1'b1;
      endcase
    end else begin
      case (op.f3)
        3'b000: ext = {{24{byte_c[7]}}, byte_c};
        3'b001: begin
          err_c = op.addr[0];
          ext   = {{16{half_c[15]}}, half_c};
        end
        3'b010: begin
          err_c = |op.addr[1:0];
          ext   = rd_word;
        end
        3'b100: ext = {24'd0, byte_c};
        3'b101: begin
          err_c = op.addr[0];
          ext   = {16'd0, half_c};
        end
        default: err_c = 1'b1;
      endcase
    end
  end

  assign ld_data = (op.wr | err_c) ? 32'd0 : ext;
  assign st_en   = enter_resp & op.wr & ~err_c;

  // Memory array: zero-fill during CLEAR, byte-enabled store on RESP entry
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_idx_q] <= 32'd0;
    end else if (st_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[op_idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      wcnt_q    <= 4'd0;
      req_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE, S_RESP: begin
          if (accept) begin
            req_q <= req_in;
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              wcnt_q  <= 4'(WAIT_STATES - 1);
              ready_q <= 1'b0;
            end else begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              valid_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
      if (enter_resp) begin
        rdata_q <= ld_data;
        err_q   <= err_c;
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign clear_busy = busy_q;

endmodule
